// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// default memory read latency.
package lsu_pkg;

  localparam int unsigned RD_LAT_DEFAULT = 1;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_WRITE,
    ST_RESP
  } state_e;

  // A request is rejected if its size is reserved or its address is not
  // naturally aligned for that size.
  function automatic logic bad_request(input size_e size, input logic [1:0] offset);
    case (size)
      SIZE_HALF: return offset[0];
      SIZE_WORD: return offset != 2'b00;
      SIZE_RSVD: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Byte-lane steering for the load/store unit: extracts and extends a load
// result from a memory word and merges sub-word store data into a word.
module byte_lane_unit
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  size_e       size_i,
  input  logic        signed_i,
  input  logic [15:0] store_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign byte_sh   = {offset_i, 3'b000};
  assign half_sh   = {offset_i[1], 4'b0000};
  assign lane_byte = word_i[byte_sh +: 8];
  assign lane_half = word_i[half_sh +: 16];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    load_data_o = word_i;
    merged_o    = word_i;
    case (size_i)
      SIZE_BYTE: begin
        load_data_o             = {{24{signed_i & lane_byte[7]}}, lane_byte};
        merged_o[byte_sh +: 8]  = store_data_i[7:0];
      end
      SIZE_HALF: begin
        load_data_o             = {{16{signed_i & lane_half[15]}}, lane_half};
        merged_o[half_sh +: 16] = store_data_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: aligns CPU byte accesses onto a word
// memory, doing read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned RD_LAT = RD_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_ren,
  output logic        mem_wen,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic        store_q, store_d;
  size_e       size_q, size_d;
  logic        signed_q, signed_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] st_data_q, st_data_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] wdata_q, wdata_d;

  logic        req_bad;
  logic        last_wait;
  logic [31:0] lane_load;
  logic [31:0] lane_merged;

  assign req_bad   = bad_request(size_e'(req_size), req_addr[1:0]);
  assign last_wait = (state_q == ST_RD_WAIT) && (cnt_q == 2'(RD_LAT - 1));

  byte_lane_unit u_lanes (
    .word_i       (mem_rdata),
    .offset_i     (addr_q[1:0]),
    .size_i       (size_q),
    .signed_i     (signed_q),
    .store_data_i (st_data_q),
    .load_data_o  (lane_load),
    .merged_o     (lane_merged)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_bad)                                   state_d = ST_RESP;
          else if (req_store && (req_size == SIZE_WORD)) state_d = ST_WRITE;
          else                                           state_d = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: state_d = ST_RD_WAIT;
      ST_RD_WAIT:  if (last_wait) state_d = store_q ? ST_WRITE : ST_RESP;
      ST_WRITE:    state_d = ST_RESP;
      ST_RESP:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    mem_ren    = (state_q == ST_RD_ISSUE);
    mem_wen    = (state_q == ST_WRITE);
    resp_valid = (state_q == ST_RESP);
    resp_err   = (state_q == ST_RESP) && err_q;
  end

  // Datapath: request capture on acceptance, read-data capture on the last
  // wait edge (load result or merged store word).
  always_comb begin
    store_d   = store_q;
    size_d    = size_q;
    signed_d  = signed_q;
    err_d     = err_q;
    addr_d    = addr_q;
    st_data_d = st_data_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    wdata_d   = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          store_d   = req_store;
          size_d    = size_e'(req_size);
          signed_d  = req_signed;
          err_d     = req_bad;
          addr_d    = req_addr;
          st_data_d = req_wdata[15:0];
          rdata_d   = '0;
          wdata_d   = (req_store && (req_size == SIZE_WORD) && !req_bad) ? req_wdata : '0;
        end
      end
      ST_RD_ISSUE: cnt_d = '0;
      ST_RD_WAIT: begin
        cnt_d = cnt_q + 2'd1;
        if (last_wait) begin
          if (store_q) wdata_d = lane_merged;
          else         rdata_d = lane_load;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      store_q   <= 1'b0;
      size_q    <= SIZE_BYTE;
      signed_q  <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      st_data_q <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      wdata_q   <= '0;
    end else begin
      store_q   <= store_d;
      size_q    <= size_d;
      signed_q  <= signed_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      st_data_q <= st_data_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      wdata_q   <= wdata_d;
    end
  end

  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = wdata_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed scenarios plus random traffic,
// checked against a byte-addressed reference memory.
module tb_load_store_unit;

  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_rdata = '0;

  load_store_unit #(.RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory seen by the DUT (RD_LAT = 1) plus strobe bookkeeping.
  logic [31:0] mem [16];
  logic [31:0] init_words [16];
  logic        preload = 1'b0;
  int          ren_cnt = 0;
  int          wen_cnt = 0;
  int          resp_cnt = 0;
  int          overlap_cnt = 0;
  logic [31:0] strobe_addr = '0;
  logic [31:0] wdata_seen = '0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_words[i];
    end else if (mem_wen) begin
      mem[mem_addr[5:2]] <= mem_wdata;
    end
    if (mem_ren) mem_rdata <= mem[mem_addr[5:2]];
    if (mem_ren && mem_wen) overlap_cnt <= overlap_cnt + 1;
    if (mem_ren) ren_cnt <= ren_cnt + 1;
    if (mem_wen) begin
      wen_cnt    <= wen_cnt + 1;
      wdata_seen <= mem_wdata;
    end
    if (mem_ren || mem_wen) strobe_addr <= mem_addr;
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  // Reference model: a flat byte array, little-endian.
  logic [7:0] ref_mem [64];
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    logic [31:0] v;
    int n;
    int base;
    n = nbytes(sz);
    base = int'(a % 64);
    v = '0;
    for (int i = 0; i < n; i++) v = v + (32'(ref_mem[base + i]) << (8 * i));
    if (sg && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v + (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int base;
    base = int'(a % 64);
    for (int i = 0; i < nbytes(sz); i++) ref_mem[base + i] = 8'(wd >> (8 * i));
  endtask

  task automatic do_txn(input string tag, input logic st, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    logic        e_err;
    logic [31:0] e_rd;
    logic [31:0] e_word;
    int          e_lat;
    int          e_ren;
    int          e_wen;
    int          ren0;
    int          wen0;
    int          lat;
    e_err  = ref_err(sz, a);
    e_rd   = (!st && !e_err) ? ref_load(sz, sg, a) : 32'h0;
    if (st && !e_err) ref_store(sz, a, wd);
    e_word = ref_load(2'd2, 1'b0, (a / 4) * 4);
    e_lat  = e_err ? 1 : (st && sz == 2'd2) ? 2 : st ? 3 + RD_LAT : 2 + RD_LAT;
    e_ren  = (e_err || (st && sz == 2'd2)) ? 0 : 1;
    e_wen  = (st && !e_err) ? 1 : 0;

    check($sformatf("%s.ready_before", tag), 32'(req_ready), 32'd1);
    ren0 = ren_cnt;
    wen0 = wen_cnt;
    req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_store  = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("%s.latency", tag), 32'(lat), 32'(e_lat));
    check($sformatf("%s.rdata", tag), resp_rdata, e_rd);
    check($sformatf("%s.err", tag), 32'(resp_err), 32'(e_err));
    check($sformatf("%s.ren_count", tag), 32'(ren_cnt - ren0), 32'(e_ren));
    check($sformatf("%s.wen_count", tag), 32'(wen_cnt - wen0), 32'(e_wen));
    if (e_wen == 1) check($sformatf("%s.mem_wdata", tag), wdata_seen, e_word);
    if (e_ren + e_wen > 0) check($sformatf("%s.mem_addr", tag), strobe_addr, (a / 4) * 4);
    @(posedge clk); #1;
    check($sformatf("%s.ready_after", tag), 32'(req_ready), 32'd1);
  endtask

  initial begin
    int ren0;
    int wen0;
    int resp0;
    reset = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 16; i++) init_words[i] = $urandom;
    init_words[4] = 32'h8844_22F1;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'(init_words[i / 4] >> (8 * (i % 4)));
    preload = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    preload = 1'b0;

    check("reset.req_ready", 32'(req_ready), 32'd1);
    check("reset.resp_valid", 32'(resp_valid), 32'd0);
    check("reset.resp_err", 32'(resp_err), 32'd0);
    check("reset.strobes", {30'd0, mem_ren, mem_wen}, 32'd0);
    check("reset.resp_rdata", resp_rdata, 32'd0);
    check("reset.mem_wdata", mem_wdata, 32'd0);
    check("reset.mem_addr", mem_addr, 32'd0);
    reset = 1'b0;

    do_txn("lb_signed",   1'b0, 2'd0, 1'b1, 32'h10, 32'h0);
    check("lb_signed.value", ref_load(2'd0, 1'b1, 32'h10), 32'hFFFF_FFF1);
    do_txn("lb_unsigned", 1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
    do_txn("lh_signed",   1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    do_txn("sb_rmw",      1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AB);
    check("sb_rmw.word", mem[4], 32'h8844_ABF1);
    do_txn("sh_misalign", 1'b1, 2'd1, 1'b0, 32'h13, 32'h1234_5678);
    do_txn("sw_direct",   1'b1, 2'd2, 1'b0, 32'h14, 32'hDEAD_BEEF);
    do_txn("lw_back",     1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
    do_txn("rsvd_size",   1'b0, 2'd3, 1'b0, 32'h20, 32'h0);
    do_txn("lw_misalign", 1'b0, 2'd2, 1'b0, 32'h22, 32'h0);

    // Reset in the read wait of a sub-word store must drop the pending write.
    ren0  = ren_cnt;
    wen0  = wen_cnt;
    resp0 = resp_cnt;
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h11; req_wdata = 32'h0000_0055;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_mid.issue_ren", 32'(mem_ren), 32'd1);
    @(posedge clk); #1;
    check("rst_mid.wait_busy", {30'd0, req_ready, mem_ren}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid.req_ready", 32'(req_ready), 32'd1);
    check("rst_mid.mem_addr", mem_addr, 32'd0);
    check("rst_mid.mem_wdata", mem_wdata, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("rst_mid.ren_count", 32'(ren_cnt - ren0), 32'd1);
    check("rst_mid.wen_count", 32'(wen_cnt - wen0), 32'd0);
    check("rst_mid.resp_count", 32'(resp_cnt - resp0), 32'd0);

    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      a = {26'($urandom), 6'($urandom)};
      do_txn($sformatf("rand%0d", k), 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
    end

    check("ren_wen_overlap", 32'(overlap_cnt), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
